// File: rtl/pid_pkg.sv
// Shared types and widths for the three-axis PID scheduler.
// Contents: datapath width constants, output saturation limits,
// the axis enum (roll/pitch/yaw) and the sequencer state enum.
package pid_pkg;

  localparam int ERR_W  = 32;
  localparam int GAIN_W = 16;
  localparam int PROD_W = 48;
  localparam int ACC_W  = 40;
  localparam int POW_W  = 13;

  // Two guard bits so p+i+dt of three 48b terms cannot wrap.
  localparam int SUM_W  = PROD_W + 2;
  // Multiplier operand B carries the widest of e (32b), d (33b), acc (40b).
  localparam int MULB_W = ACC_W + 1;
  localparam int MUL_W  = GAIN_W + MULB_W;

  localparam longint POW_MAX = (longint'(1) <<< (POW_W - 1)) - 1;
  localparam longint POW_MIN = -(longint'(1) <<< (POW_W - 1));

  typedef enum logic [1:0] {
    AX_ROLL  = 2'd0,
    AX_PITCH = 2'd1,
    AX_YAW   = 2'd2
  } axis_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P    = 3'd1,
    S_I    = 3'd2,
    S_D    = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/pid_sat.sv
// Parametric signed clamp: limits x_i to [LO, HI] and narrows it to OUT_W bits.
// Ports:
//   x_i  in  IN_W   signed value to clamp (IN_W <= 64)
//   y_o  out OUT_W  clamped value; LO/HI must be representable in OUT_W
module pid_sat #(
  parameter int     IN_W  = 41,
  parameter int     OUT_W = 40,
  parameter longint LO    = -1,
  parameter longint HI    = 1
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [OUT_W-1:0] y_o
);

  logic signed [63:0] x_ext;

  assign x_ext = 64'(x_i);

  always_comb begin
    if (x_ext > HI) begin
      y_o = OUT_W'(HI);
    end else if (x_ext < LO) begin
      y_o = OUT_W'(LO);
    end else begin
      y_o = OUT_W'(x_i);
    end
  end

endmodule

// File: rtl/pid_axis_sched.sv
// Time-multiplexed PID for roll, pitch and yaw sharing one signed multiplier.
// A data_ready pulse latches the three errors; each axis then takes four
// states (P, I, D, OUT) and the three 13-bit powers are published together
// with a one-cycle valid in the DONE state (13 cycles after data_ready).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   data_ready           one-cycle pulse, new errors valid
//   err_roll/pitch/yaw   signed 32b rate errors, 18 fractional bits
//   armed                (only with PID_ARM_GATE_EN) 0 zeroes state and powers
//   clr_overrun          clears the sticky overrun flag
//   power_roll/pitch/yaw signed 13b commands
//   valid                one-cycle pulse when powers update
//   busy                 high in P/I/D/OUT
//   overrun              sticky, set when data_ready arrives while busy
// Build option: define PID_ARM_GATE_EN to add the armed input.
module pid_axis_sched
  import pid_pkg::*;
#(
  parameter logic signed [GAIN_W-1:0] KP_RP = 16'sd1,
  parameter logic signed [GAIN_W-1:0] KI_RP = 16'sd0,
  parameter logic signed [GAIN_W-1:0] KD_RP = 16'sd0,
  parameter logic signed [GAIN_W-1:0] KP_Y  = 16'sd1,
  parameter logic signed [GAIN_W-1:0] KI_Y  = 16'sd0,
  parameter logic signed [GAIN_W-1:0] KD_Y  = 16'sd0,
  parameter longint ACC_MAX   = (longint'(1) <<< 36) - 1,
  parameter longint MAX_ITERM = longint'(1024) <<< 18,
  parameter int     OUT_SHIFT = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_ready,
  input  logic signed [ERR_W-1:0] err_roll,
  input  logic signed [ERR_W-1:0] err_pitch,
  input  logic signed [ERR_W-1:0] err_yaw,
`ifdef PID_ARM_GATE_EN
  input  logic                    armed,
`endif
  input  logic                    clr_overrun,
  output logic signed [POW_W-1:0] power_roll,
  output logic signed [POW_W-1:0] power_pitch,
  output logic signed [POW_W-1:0] power_yaw,
  output logic                    valid,
  output logic                    busy,
  output logic                    overrun
);

  state_e state_q, state_d;
  axis_e  ax_q;

  logic signed [ERR_W-1:0]  e_q    [3];
  logic signed [ACC_W-1:0]  acc_q  [3];
  logic signed [ERR_W-1:0]  prev_q [3];
  logic signed [PROD_W-1:0] p_q, i_q, dt_q;
  // Roll/pitch results wait here so all three outputs change on one edge.
  logic signed [POW_W-1:0]  pw_q   [2];
  logic signed [POW_W-1:0]  pow_q  [3];
  logic                     valid_q, overrun_q;

  logic                     armed_w;
  logic                     busy_w;
  logic signed [ERR_W-1:0]  e_cur;
  logic signed [ERR_W:0]    diff;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [GAIN_W-1:0] k_mul;
  logic signed [MULB_W-1:0] b_mul;
  logic signed [MUL_W-1:0]  prod;
  logic signed [PROD_W-1:0] iterm;
  logic signed [SUM_W-1:0]  sum, sum_sh;
  logic signed [POW_W-1:0]  pow_sat, pow_new;

`ifdef PID_ARM_GATE_EN
  assign armed_w = armed;
`else
  assign armed_w = 1'b1;
`endif

  assign busy_w  = (state_q == S_P) || (state_q == S_I) ||
                   (state_q == S_D) || (state_q == S_OUT);
  assign e_cur   = e_q[ax_q];
  assign diff    = (ERR_W+1)'(e_cur) - (ERR_W+1)'(prev_q[ax_q]);
  assign acc_sum = (ACC_W+1)'(acc_q[ax_q]) + (ACC_W+1)'(e_cur);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (data_ready) state_d = S_P;
      S_P:     state_d = S_I;
      S_I:     state_d = S_D;
      S_D:     state_d = S_OUT;
      S_OUT:   state_d = (ax_q == AX_YAW) ? S_DONE : S_P;
      S_DONE:  state_d = data_ready ? S_P : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared multiplier: the state picks which term is formed this cycle.
  always_comb begin
    k_mul = (ax_q == AX_YAW) ? KP_Y : KP_RP;
    b_mul = MULB_W'(e_cur);
    case (state_q)
      S_I: begin
        k_mul = (ax_q == AX_YAW) ? KI_Y : KI_RP;
        b_mul = MULB_W'(acc_next);
      end
      S_D: begin
        k_mul = (ax_q == AX_YAW) ? KD_Y : KD_RP;
        b_mul = MULB_W'(diff);
      end
      default: ;
    endcase
  end

  assign prod = MUL_W'(k_mul) * MUL_W'(b_mul);

  pid_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W), .LO(-ACC_MAX), .HI(ACC_MAX))
    u_acc_sat (.x_i(acc_sum), .y_o(acc_next));

  pid_sat #(.IN_W(MUL_W), .OUT_W(PROD_W), .LO(-MAX_ITERM), .HI(MAX_ITERM))
    u_iterm_sat (.x_i(prod), .y_o(iterm));

  assign sum    = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(dt_q);
  assign sum_sh = sum >>> OUT_SHIFT;

  pid_sat #(.IN_W(SUM_W), .OUT_W(POW_W), .LO(POW_MIN), .HI(POW_MAX))
    u_out_sat (.x_i(sum_sh), .y_o(pow_sat));

  assign pow_new = armed_w ? pow_sat : '0;

  // Control and per-axis state: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ax_q      <= AX_ROLL;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        acc_q[a]  <= '0;
        prev_q[a] <= '0;
        pow_q[a]  <= '0;
      end
      pw_q[0] <= '0;
      pw_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= (state_q == S_OUT) && (ax_q == AX_YAW);
      // A new drop wins over a simultaneous clear.
      overrun_q <= (data_ready && busy_w) ? 1'b1 :
                   (clr_overrun ? 1'b0 : overrun_q);
      case (state_q)
        S_IDLE, S_DONE: if (data_ready) ax_q <= AX_ROLL;
        S_I:   acc_q[ax_q]  <= armed_w ? acc_next : '0;
        S_D:   prev_q[ax_q] <= armed_w ? e_cur : '0;
        S_OUT: begin
          case (ax_q)
            AX_ROLL: begin
              pw_q[0] <= pow_new;
              ax_q    <= AX_PITCH;
            end
            AX_PITCH: begin
              pw_q[1] <= pow_new;
              ax_q    <= AX_YAW;
            end
            default: begin
              pow_q[0] <= pw_q[0];
              pow_q[1] <= pw_q[1];
              pow_q[2] <= pow_new;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: only ever read after being written in-sequence.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE, S_DONE: begin
        if (data_ready) begin
          e_q[0] <= err_roll;
          e_q[1] <= err_pitch;
          e_q[2] <= err_yaw;
        end
      end
      S_P:     p_q  <= PROD_W'(prod);
      S_I:     i_q  <= iterm;
      S_D:     dt_q <= PROD_W'(prod);
      default: ;
    endcase
  end

  assign power_roll  = pow_q[0];
  assign power_pitch = pow_q[1];
  assign power_yaw   = pow_q[2];
  assign valid       = valid_q;
  assign busy        = busy_w;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pid_axis_sched.sv
// Self-checking bench for pid_axis_sched. Four instances share the inputs:
//   u0 default gains (KP=1), u1 pure integral, u2 pure derivative,
//   u3 mixed gains with small clamps, checked against a reference model.
module tb_pid_axis_sched;

  logic               clk = 1'b0;
  logic               rst, data_ready, clr_overrun;
  logic signed [31:0] err_roll, err_pitch, err_yaw;
`ifdef PID_ARM_GATE_EN
  logic               armed;
`endif
  logic signed [12:0] pr [4];
  logic signed [12:0] pp [4];
  logic signed [12:0] py [4];
  logic               v  [4];
  logic               bz [4];
  logic               ov [4];

  int ntests, nfail, cyc;

  always #5 clk = ~clk;

  pid_axis_sched u0 (
    .clk(clk), .rst(rst), .data_ready(data_ready),
    .err_roll(err_roll), .err_pitch(err_pitch), .err_yaw(err_yaw),
`ifdef PID_ARM_GATE_EN
    .armed(armed),
`endif
    .clr_overrun(clr_overrun),
    .power_roll(pr[0]), .power_pitch(pp[0]), .power_yaw(py[0]),
    .valid(v[0]), .busy(bz[0]), .overrun(ov[0]));

  pid_axis_sched #(.KP_RP(16'sd0), .KI_RP(16'sd1), .KP_Y(16'sd0), .KI_Y(16'sd1)) u1 (
    .clk(clk), .rst(rst), .data_ready(data_ready),
    .err_roll(err_roll), .err_pitch(err_pitch), .err_yaw(err_yaw),
`ifdef PID_ARM_GATE_EN
    .armed(armed),
`endif
    .clr_overrun(clr_overrun),
    .power_roll(pr[1]), .power_pitch(pp[1]), .power_yaw(py[1]),
    .valid(v[1]), .busy(bz[1]), .overrun(ov[1]));

  pid_axis_sched #(.KP_RP(16'sd0), .KD_RP(16'sd2), .KP_Y(16'sd0)) u2 (
    .clk(clk), .rst(rst), .data_ready(data_ready),
    .err_roll(err_roll), .err_pitch(err_pitch), .err_yaw(err_yaw),
`ifdef PID_ARM_GATE_EN
    .armed(armed),
`endif
    .clr_overrun(clr_overrun),
    .power_roll(pr[2]), .power_pitch(pp[2]), .power_yaw(py[2]),
    .valid(v[2]), .busy(bz[2]), .overrun(ov[2]));

  pid_axis_sched #(.KP_RP(16'sd3), .KI_RP(16'sd2), .KD_RP(-16'sd1),
                   .KP_Y(-16'sd2), .KI_Y(16'sd1), .KD_Y(16'sd4),
                   .ACC_MAX(longint'(1) <<< 31), .MAX_ITERM(longint'(1000) <<< 18)) u3 (
    .clk(clk), .rst(rst), .data_ready(data_ready),
    .err_roll(err_roll), .err_pitch(err_pitch), .err_yaw(err_yaw),
`ifdef PID_ARM_GATE_EN
    .armed(armed),
`endif
    .clr_overrun(clr_overrun),
    .power_roll(pr[3]), .power_pitch(pp[3]), .power_yaw(py[3]),
    .valid(v[3]), .busy(bz[3]), .overrun(ov[3]));

  // Reference model for u3: plain arithmetic over the PID rules.
  localparam longint M_KP[3] = '{3, 3, -2};
  localparam longint M_KI[3] = '{2, 2, 1};
  localparam longint M_KD[3] = '{-1, -1, 4};
  localparam longint M_ACCMAX = longint'(1) <<< 31;
  localparam longint M_ITMAX  = longint'(1000) <<< 18;
  longint m_acc[3], m_prev[3], m_e[3], m_pw[3];

  function automatic longint clampl(longint x, longint lo, longint hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  task automatic model_frame();
    longint it, s;
    for (int a = 0; a < 3; a++) begin
      m_acc[a]  = clampl(m_acc[a] + m_e[a], -M_ACCMAX, M_ACCMAX);
      it        = clampl(M_KI[a] * m_acc[a], -M_ITMAX, M_ITMAX);
      s         = M_KP[a] * m_e[a] + it + M_KD[a] * (m_e[a] - m_prev[a]);
      m_prev[a] = m_e[a];
      m_pw[a]   = clampl(s >>> 18, -4096, 4095);
    end
  endtask

  task automatic chk(input string nm, input longint got, input longint exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle 1 (first cycle after edge 0).
  task automatic start_frame(input int r, input int p, input int y);
    @(negedge clk);
    err_roll = r; err_pitch = p; err_yaw = y;
    data_ready = 1'b1;
    cyc = 0;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic wait_valid(output int at, output int busy_cnt);
    busy_cnt = 0;
    while (v[0] !== 1'b1 && cyc < 40) begin
      if (bz[0] === 1'b1) busy_cnt++;
      tick();
    end
    at = cyc;
    if (v[0] !== 1'b1) begin
      ntests++;
      nfail++;
      $display("FAIL valid_timeout: got no valid, expected one by cycle 40");
    end
  endtask

  typedef struct {
    int r, p, y;
    int er, ep, ey;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int at, bc, nv;
    ntests = 0; nfail = 0; cyc = 0;
    rst = 1'b1; data_ready = 1'b0; clr_overrun = 1'b0;
    err_roll = '0; err_pitch = '0; err_yaw = '0;
`ifdef PID_ARM_GATE_EN
    armed = 1'b1;
`endif
    vt[0] = '{100 << 18, -7 << 18, 0, 100, -7, 0};
    vt[1] = '{5000 << 18, -5000 << 18, 0, 4095, -4096, 0};
    vt[2] = '{4095 << 18, -4096 << 18, 1 << 18, 4095, -4096, 1};
    vt[3] = '{4096 << 18, -4097 << 18, -1 << 18, 4095, -4096, -1};
    vt[4] = '{917504, -131072, 1835007, 3, -1, 6};
    vt[5] = '{2147483647, int'(32'h80000000), 0, 4095, -4096, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_power_roll", pr[0], 0);
    chk("rst_power_pitch", pp[0], 0);
    chk("rst_power_yaw", py[0], 0);
    chk("rst_valid", v[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_overrun", ov[0], 0);

    // Proportional-only vectors, including saturation and fractional floors.
    for (int k = 0; k < 6; k++) begin
      start_frame(vt[k].r, vt[k].p, vt[k].y);
      wait_valid(at, bc);
      if (k == 0) begin
        chk("latency", at, 13);
        chk("busy_cycles", bc, 12);
        chk("busy_in_done", bz[0], 0);
      end
      chk($sformatf("vec%0d_roll", k), pr[0], vt[k].er);
      chk($sformatf("vec%0d_pitch", k), pp[0], vt[k].ep);
      chk($sformatf("vec%0d_yaw", k), py[0], vt[k].ey);
      if (k == 0) begin
        tick();
        chk("valid_one_cycle", v[0], 0);
      end
    end

    // Integrator accumulates across frames and is cleared by reset.
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      start_frame(10 << 18, 0, 0);
      wait_valid(at, bc);
      chk($sformatf("ki_frame%0d", f), pr[1], 10 * f);
    end
    do_reset();
    start_frame(10 << 18, 0, 0);
    wait_valid(at, bc);
    chk("ki_after_rst", pr[1], 10);

    // Derivative uses the previous frame's error.
    do_reset();
    start_frame(0, 0, 0);
    wait_valid(at, bc);
    chk("kd_frame0", pr[2], 0);
    start_frame(50 << 18, 0, 0);
    wait_valid(at, bc);
    chk("kd_frame1", pr[2], 100);
    start_frame(50 << 18, 0, 0);
    wait_valid(at, bc);
    chk("kd_frame2", pr[2], 0);

    // data_ready while busy is dropped; errors latched at start.
    do_reset();
    start_frame(100 << 18, 1 << 18, 2 << 18);
    while (cyc < 5) tick();
    data_ready = 1'b1;
    err_roll = 999 << 18;
    tick();
    data_ready = 1'b0;
    wait_valid(at, bc);
    chk("ovr_latency", at, 13);
    chk("ovr_flag", ov[0], 1);
    chk("latched_err", pr[0], 100);
    nv = 0;
    repeat (10) begin
      tick();
      if (v[0] === 1'b1) nv++;
    end
    chk("single_valid", nv, 0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clear", ov[0], 0);

    // Back-to-back: data_ready in DONE is accepted; outputs hold until next DONE.
    start_frame(100 << 18, -7 << 18, 5 << 18);
    wait_valid(at, bc);
    data_ready = 1'b1;
    err_roll = 200 << 18; err_pitch = -3 << 18; err_yaw = 9 << 18;
    tick();
    data_ready = 1'b0;
    while (cyc < 20) tick();
    chk("hold_roll", pr[0], 100);
    wait_valid(at, bc);
    chk("b2b_latency", at, 26);
    chk("b2b_roll", pr[0], 200);
    chk("b2b_pitch", pp[0], -3);
    chk("b2b_yaw", py[0], 9);
    chk("b2b_no_overrun", ov[0], 0);

    // Set and clear in the same cycle: set wins.
    start_frame(1 << 18, 2 << 18, 3 << 18);
    while (cyc < 3) tick();
    data_ready = 1'b1;
    clr_overrun = 1'b1;
    tick();
    data_ready = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_wins", ov[0], 1);
    wait_valid(at, bc);

    // Reset mid-sequence aborts without a valid.
    start_frame(100 << 18, -7 << 18, 55 << 18);
    while (cyc < 7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", bz[0], 0);
    chk("midrst_valid", v[0], 0);
    chk("midrst_roll", pr[0], 0);
    chk("midrst_pitch", pp[0], 0);
    chk("midrst_yaw", py[0], 0);
    chk("midrst_overrun", ov[0], 0);
    nv = 0;
    repeat (15) begin
      tick();
      if (v[0] === 1'b1) nv++;
    end
    chk("midrst_no_valid", nv, 0);

`ifdef PID_ARM_GATE_EN
    armed = 1'b0;
    start_frame(100 << 18, -7 << 18, 55 << 18);
    wait_valid(at, bc);
    chk("disarmed_latency", at, 13);
    chk("disarmed_roll", pr[0], 0);
    chk("disarmed_pitch", pp[0], 0);
    chk("disarmed_yaw", py[0], 0);
    armed = 1'b1;
`endif

    // Randomized frames against the model, exercising both clamps.
    do_reset();
    for (int a = 0; a < 3; a++) begin
      m_acc[a] = 0;
      m_prev[a] = 0;
    end
    for (int n = 0; n < 60; n++) begin
      m_e[0] = longint'($urandom_range(0, 500 << 18));
      m_e[1] = longint'($urandom_range(0, 1000 << 18)) - (longint'(500) <<< 18);
      m_e[2] = -longint'($urandom_range(0, 300 << 18));
      model_frame();
      start_frame(int'(m_e[0]), int'(m_e[1]), int'(m_e[2]));
      wait_valid(at, bc);
      chk($sformatf("rnd%0d_roll", n), pr[3], m_pw[0]);
      chk($sformatf("rnd%0d_pitch", n), pp[3], m_pw[1]);
      chk($sformatf("rnd%0d_yaw", n), py[3], m_pw[2]);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pid_axis_sched.md
Name: pid_axis_sched

Overview:
Time-multiplexed PID scheduler for the three flight axes (roll, pitch, yaw). On each IMU `data_ready` it latches three rate errors and walks them through one shared signed multiplier. Per axis it computes the P, I and D terms, sums them and saturates the result. It holds per-axis integrator and previous-error state. It emits three 13-bit motor-mixer power commands with a one-cycle valid strobe.

Parameters:
KP_RP, 1, proportional gain, roll/pitch (signed 16b)
KI_RP, 0, integral gain, roll/pitch (signed 16b)
KD_RP, 0, derivative gain, roll/pitch (signed 16b)
KP_Y, 1, proportional gain, yaw (signed 16b)
KI_Y, 0, integral gain, yaw (signed 16b)
KD_Y, 0, derivative gain, yaw (signed 16b)
ACC_MAX, 2**36-1, integrator clamp magnitude (40b accumulator)
MAX_ITERM, 1024<<18, I-term clamp magnitude (product domain)
OUT_SHIFT, 18, fractional bits removed before output saturation

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
data_ready  in  1  one-cycle pulse: new errors valid
err_roll  in  32  signed rate error, 18 fractional bits
err_pitch  in  32  same, pitch
err_yaw  in  32  same, yaw
clr_overrun  in  1  clears overrun flag
power_roll  out  13  signed command
power_pitch  out  13  signed command
power_yaw  out  13  signed command
valid  out  1  one-cycle pulse: powers updated
busy  out  1  sequencing in progress
overrun  out  1  sticky: data_ready dropped

Behaviour:
- Reset (clk, rst sync active-high) clears all outputs to 0, acc[0..2] to 0, prev[0..2] to 0, and the FSM to IDLE. Reset mid-sequence aborts the sequence; no valid is emitted.
- FSM states: IDLE, P, I, D, OUT, DONE. Axis index ax runs 0..2.
  - IDLE or DONE with data_ready: latch the three errors, ax=0, go to P.
  - DONE without data_ready: go to IDLE.
  - P → I → D → OUT.
  - OUT with ax<2: ax++ and go to P. OUT with ax==2: go to DONE.
- Arithmetic per axis, one multiply per state, 48b products:
  - P: p = KP·e.
  - I: acc_next = clamp(acc[ax]+e, ±ACC_MAX); i = clamp(KI·acc_next, ±MAX_ITERM); acc[ax] ← acc_next.
  - D: d = e − prev[ax]; dt = KD·d; prev[ax] ← e.
  - OUT: s = p+i+dt in 50b; power[ax] ← sat13(s >>> OUT_SHIFT), arithmetic shift, range [−4096, 4095].
- Gains are selected by ax: roll/pitch share the _RP gains, yaw uses the _Y gains.
- Latency: data_ready sampled at edge 0; valid is high in cycle 13 (DONE), for one cycle. All three powers are stable from that edge and hold until the next DONE.
- busy is 1 in P/I/D/OUT and 0 in IDLE/DONE.
- data_ready while busy is ignored. overrun ← 1, sticky until rst or clr_overrun. If set and clear occur in the same cycle, set wins.
- data_ready in DONE is accepted: back-to-back frames every 13 cycles.
- Errors are latched once at start; later changes to the err_* inputs do not affect the current sequence.

Optional Feature:
- Macro PID_ARM_GATE_EN.
- Defined: adds input port `armed` (1b). While armed==0:
  - acc[ax] and prev[ax] are written to 0 instead of updated.
  - OUT writes power 0.
  - Sequencing and valid timing are unchanged.
- Undefined: no port; behaviour as if always armed.

Decomposition:
- Package pid_pkg:
  - axis enum: AX_ROLL=0, AX_PITCH=1, AX_YAW=2.
  - FSM state enum.
  - Width constants: ERR_W=32, GAIN_W=16, PROD_W=48, ACC_W=40, POW_W=13.
  - POW_MIN/POW_MAX.
- One natural sub-module, pid_sat: parametric signed clamp/saturate. Used for the acc, I-term and output clamps.

Test Plan:
- KP=1, others 0; err_roll=100<<18, err_pitch=−7<<18, err_yaw=0 → valid at cycle 13; powers 100, −7, 0; busy high cycles 1–12.
- err_roll=5000<<18 and err_pitch=−5000<<18 → power_roll=4095, power_pitch=−4096.
- KP=0, KI_RP=1; three frames with err_roll=10<<18 → power_roll 10, 20, 30. rst, then one frame → 10.
- KP=0, KD_RP=2; err_roll 0 then 50<<18 then 50<<18 → power_roll 0, 100, 0.
- data_ready at cycle 0 and again at cycle 5 → second ignored, overrun=1, single valid at 13. clr_overrun → 0. data_ready at cycle 13 → accepted, next valid at 26.
- rst asserted at cycle 7 of a sequence → no valid; outputs 0; IDLE next cycle. With PID_ARM_GATE_EN and armed=0: valid still at 13 with all powers 0.
